// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and constants for the instruction-memory arbiter
//   state_t : arbiter FSM states
//   grant_t : round-robin last-served encoding
package imem_arb_pkg;
   localparam int ADDR_W = 8;
   localparam int BYTES_PER_WORD = 4;
   typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;
   typedef enum logic {GNT_FETCH, GNT_LOAD} grant_t;
endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch port, loader port and byte-memory port of imem_arbiter
//   slave  : arbiter side (drives ready/done/instr/err, mem_addr/we/wdata, busy)
//   master : requesters and memory array side
interface imem_arbiter_if #(parameter int ADDR_W = imem_arb_pkg::ADDR_W);
   logic              fetch_valid;
   logic [31:0]       fetch_addr;
   logic              fetch_ready;
   logic              fetch_done;
   logic [31:0]       fetch_instr;
   logic              fetch_err;
   logic              load_valid;
   logic [ADDR_W-1:0] load_addr;
   logic [7:0]        load_data;
   logic              load_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              busy;
   modport slave (
      input  fetch_valid, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
      output fetch_ready, fetch_done, fetch_instr, fetch_err, load_ready, mem_addr, mem_we, mem_wdata, busy
   );
   modport master (
      output fetch_valid, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
      input  fetch_ready, fetch_done, fetch_instr, fetch_err, load_ready, mem_addr, mem_we, mem_wdata, busy
   );
endinterface

// File: rtl/imem_rr_arb2.sv
// imem_rr_arb2: two-requester round-robin arbiter
//   en                  : arbitration allowed this cycle
//   req_fetch, req_load : requests
//   gnt                 : one-hot grant, gnt[0] fetch, gnt[1] load
// On a tie the requester not served last wins; last-served resets to load.
module imem_rr_arb2
   import imem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       req_fetch,
   input  logic       req_load,
   output logic [1:0] gnt
);
   grant_t last;
   logic gf, gl;

   assign gf = en && req_fetch && (!req_load || last == GNT_LOAD);
   assign gl = en && req_load && !gf;
   assign gnt = {gl, gf};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last <= GNT_LOAD;
      else if (gf || gl) last <= gf ? GNT_FETCH : GNT_LOAD;
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a byte-wide big-endian instruction memory between a
// 32-bit fetch port (four-beat read burst) and a byte-write loader port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : imem_arbiter_if.slave (fetch, load, memory handshakes, busy)
// Optional IMEM_ALIGN_CHECK_EN: misaligned fetches finish at once with
// fetch_err and a zero word instead of being burst-read.
module imem_arbiter
   import imem_arb_pkg::*;
(
   input logic           clk,
   input logic           rst_n,
   imem_arbiter_if.slave bus
);
   state_t state, state_n;
   logic [2:0] cnt, cnt_n;
   logic [ADDR_W-1:0] base, ld_addr;
   logic [7:0] ld_data;
   logic [23:0] acc;
   logic [31:0] held, word;
   logic err, mis;
   logic [1:0] gnt;
   logic unused_addr;

   assign unused_addr = ^bus.fetch_addr[31:ADDR_W];

`ifdef IMEM_ALIGN_CHECK_EN
   assign mis = bus.fetch_addr[1:0] != 2'b00;
   assign bus.fetch_err = bus.fetch_done && err;
`else
   assign mis = 1'b0;
   assign bus.fetch_err = 1'b0;
`endif

   imem_rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (state == IDLE),
      .req_fetch (bus.fetch_valid),
      .req_load  (bus.load_valid),
      .gnt       (gnt)
   );

   assign bus.fetch_ready = gnt[0];
   assign bus.load_ready = gnt[1];
   assign bus.busy = state != IDLE;
   assign bus.fetch_done = state == FETCH && cnt == 3'(BYTES_PER_WORD);
   // Beat 3 arrives on mem_rdata in the done cycle, so the word is completed combinationally
   assign word = err ? '0 : {acc, bus.mem_rdata};
   assign bus.fetch_instr = bus.fetch_done ? word : held;
   assign bus.mem_we = state == LOAD;
   assign bus.mem_wdata = bus.mem_we ? ld_data : '0;
   assign bus.mem_addr = bus.mem_we ? ld_addr : (state == FETCH && !cnt[2]) ? base + ADDR_W'(cnt) : '0;

   always_comb begin
      state_n = state;
      cnt_n = cnt;
      case (state)
         IDLE: begin
            state_n = gnt[0] ? FETCH : gnt[1] ? LOAD : IDLE;
            // A misaligned fetch skips the reads and lands directly on the done beat
            cnt_n = (gnt[0] && mis) ? 3'(BYTES_PER_WORD) : 3'd0;
         end
         FETCH: begin
            state_n = bus.fetch_done ? IDLE : FETCH;
            cnt_n = bus.fetch_done ? 3'd0 : cnt + 3'd1;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         base <= '0;
         ld_addr <= '0;
         ld_data <= '0;
         acc <= '0;
         held <= '0;
         err <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         if (gnt[0]) begin
            base <= bus.fetch_addr[ADDR_W-1:0];
            err <= mis;
         end
         if (gnt[1]) begin
            ld_addr <= bus.load_addr;
            ld_data <= bus.load_data;
         end
         // Read data lags the address by one beat: beats 0..2 are shifted in at cnt 1..3
         if (state == FETCH && cnt != 3'd0 && !bus.fetch_done) acc <= {acc[15:0], bus.mem_rdata};
         if (bus.fetch_done) held <= word;
      end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: self-checking bench for imem_arbiter (table vectors, directed corner cases, random traffic vs reference model)
module tb_imem_arbiter;
`ifdef IMEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   typedef struct {
      bit          ld;
      logic [31:0] addr;
      logic [7:0]  data;
      logic [31:0] exp;
      bit          mis;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   bit [7:0] mem [256];
   bit [7:0] ref_mem [256];
   vec_t tbl [12];

   imem_arbiter_if bus ();
   imem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference model: transaction timing from the handshake cycle, memory image, round-robin rule
   int m_free = 0, m_done_at = -100, m_we_at = -100, m_rd_at = -100;
   bit m_last_load = 1'b1, m_err = 1'b0;
   logic [31:0] m_word = '0, m_pend = '0;
   logic [7:0] m_base, m_la, m_ld, ra;
   bit idle, efr, elr, done;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_free = 0; m_done_at = -100; m_we_at = -100; m_rd_at = -100;
         m_last_load = 1'b1; m_err = 1'b0; m_word = '0;
         chk("rst_busy", bus.busy, 0);
         chk("rst_mem_we", bus.mem_we, 0);
         chk("rst_fetch_done", bus.fetch_done, 0);
         chk("rst_fetch_instr", bus.fetch_instr, 0);
      end else begin
         idle = cyc >= m_free;
         efr = idle && bus.fetch_valid && (!bus.load_valid || m_last_load);
         elr = idle && bus.load_valid && !efr;
         done = cyc == m_done_at;
         chk("busy", bus.busy, !idle);
         chk("fetch_ready", bus.fetch_ready, efr);
         chk("load_ready", bus.load_ready, elr);
         chk("fetch_done", bus.fetch_done, done);
         chk("fetch_err", bus.fetch_err, done && m_err);
         if (done) m_word = m_pend;
         chk("fetch_instr", bus.fetch_instr, m_word);
         chk("mem_we", bus.mem_we, cyc == m_we_at);
         if (cyc == m_we_at) begin
            chk("wr_addr", bus.mem_addr, m_la);
            chk("wr_data", bus.mem_wdata, m_ld);
         end
         if (cyc >= m_rd_at && cyc < m_rd_at + 4) begin
            ra = m_base + 8'(cyc - m_rd_at);
            chk("rd_addr", bus.mem_addr, ra);
         end else if (idle) chk("idle_addr", bus.mem_addr, 0);
         if (efr) begin
            m_base = bus.fetch_addr[7:0];
            m_last_load = 1'b0;
            m_err = ALIGN && bus.fetch_addr[1:0] != 2'b00;
            if (m_err) begin
               m_pend = '0; m_rd_at = -100; m_done_at = cyc + 1; m_free = cyc + 2;
            end else begin
               for (int k = 0; k < 4; k++) begin
                  ra = m_base + 8'(k);
                  m_pend = {m_pend[23:0], ref_mem[ra]};
               end
               m_rd_at = cyc + 1; m_done_at = cyc + 5; m_free = cyc + 6;
            end
         end else if (elr) begin
            m_la = bus.load_addr; m_ld = bus.load_data;
            ref_mem[m_la] = m_ld;
            m_last_load = 1'b1; m_we_at = cyc + 1; m_free = cyc + 2;
         end
      end
   end

   task automatic do_req(input vec_t v);
      int n, lat, wes;
      bit hs, em;
      @(posedge clk); #1;
      bus.fetch_valid = !v.ld; bus.fetch_addr = v.addr;
      bus.load_valid = v.ld; bus.load_addr = v.addr[7:0]; bus.load_data = v.data;
      n = 0;
      do begin @(negedge clk); n++; hs = v.ld ? bus.load_ready : bus.fetch_ready; end while (!hs && n < 20);
      chk("handshake", hs, 1);
      @(posedge clk); #1;
      bus.fetch_valid = 1'b0; bus.load_valid = 1'b0;
      if (v.ld) begin
         wes = 0;
         repeat (3) begin
            @(negedge clk);
            if (bus.mem_we) begin
               wes++;
               chk("load_addr", bus.mem_addr, v.addr[7:0]);
               chk("load_data", bus.mem_wdata, v.data);
            end
         end
         chk("load_we_count", wes, 1);
      end else begin
         em = ALIGN && v.mis;
         lat = 0;
         do begin @(negedge clk); lat++; end while (!bus.fetch_done && lat < 10);
         chk("fetch_latency", lat, em ? 1 : 5);
         chk("fetch_word", bus.fetch_instr, em ? 32'h0 : v.exp);
         chk("fetch_err_flag", bus.fetch_err, em);
      end
   endtask

   initial begin
      bit fh, lh, hs;
      int n, dn, rn;
      bit q [$];
      bus.fetch_valid = 1'b0; bus.fetch_addr = '0;
      bus.load_valid = 1'b0; bus.load_addr = '0; bus.load_data = '0;
      repeat (3) @(posedge clk); #1;
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_fetch_err", bus.fetch_err, 0);
      chk("rst_fetch_ready", bus.fetch_ready, 0);
      rst_n = 1'b1;

      // Tie from reset: fetch first, then strict alternation
      @(posedge clk); #1;
      bus.fetch_valid = 1'b1; bus.fetch_addr = 32'h0;
      bus.load_valid = 1'b1; bus.load_addr = 8'h40; bus.load_data = 8'h5A;
      for (int i = 0; i < 40 && q.size() < 4; i++) begin
         @(negedge clk);
         if (bus.fetch_valid && bus.fetch_ready) q.push_back(1'b0);
         else if (bus.load_valid && bus.load_ready) q.push_back(1'b1);
      end
      @(posedge clk); #1;
      bus.fetch_valid = 1'b0; bus.load_valid = 1'b0;
      chk("tie_count", q.size(), 4);
      for (int k = 0; k < q.size(); k++) chk("tie_order", q[k], k % 2);
      repeat (8) @(posedge clk);

      tbl[0]  = '{1'b1, 32'h00, 8'h20, 32'h0, 1'b0};
      tbl[1]  = '{1'b1, 32'h01, 8'h08, 32'h0, 1'b0};
      tbl[2]  = '{1'b1, 32'h02, 8'h00, 32'h0, 1'b0};
      tbl[3]  = '{1'b1, 32'h03, 8'h05, 32'h0, 1'b0};
      tbl[4]  = '{1'b1, 32'hFE, 8'hDE, 32'h0, 1'b0};
      tbl[5]  = '{1'b1, 32'hFF, 8'hAD, 32'h0, 1'b0};
      tbl[6]  = '{1'b0, 32'h00, 8'h00, 32'h20080005, 1'b0};
      tbl[7]  = '{1'b1, 32'h10, 8'hAB, 32'h0, 1'b0};
      tbl[8]  = '{1'b0, 32'h10, 8'h00, 32'hAB000000, 1'b0};
      tbl[9]  = '{1'b0, 32'hFE, 8'h00, 32'hDEAD2008, 1'b1};
      tbl[10] = '{1'b0, 32'hFFFFFF00, 8'h00, 32'h20080005, 1'b0};
      tbl[11] = '{1'b0, 32'h103, 8'h00, 32'h05000000, 1'b1};
      for (int i = 0; i < 12; i++) do_req(tbl[i]);

      // Load held during a fetch waits until the fetch completes
      @(posedge clk); #1;
      bus.fetch_valid = 1'b1; bus.fetch_addr = 32'h0;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.fetch_ready && n < 20);
      chk("b_fetch_hs", bus.fetch_ready, 1);
      @(posedge clk); #1;
      bus.fetch_valid = 1'b0;
      bus.load_valid = 1'b1; bus.load_addr = 8'h30; bus.load_data = 8'hC3;
      n = 0; dn = 0;
      do begin @(negedge clk); n++; if (bus.fetch_done) dn = n; end while (!bus.load_ready && n < 20);
      chk("b_done_cycle", dn, 5);
      chk("b_load_ready_cycle", n, 6);
      @(posedge clk); #1;
      bus.load_valid = 1'b0;
      @(negedge clk);
      chk("b_we_after_done", bus.mem_we, 1);
      chk("b_we_addr", bus.mem_addr, 8'h30);

      // Reset at cnt=2 of a burst
      @(posedge clk); #1;
      bus.fetch_valid = 1'b1; bus.fetch_addr = 32'h4;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.fetch_ready && n < 20);
      @(posedge clk); #1;
      bus.fetch_valid = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("c_busy_mid", bus.busy, 1);
      chk("c_addr_cnt2", bus.mem_addr, 8'h06);
      chk("c_instr_before", bus.fetch_instr, 32'h20080005);
      rst_n = 1'b0; #1;
      chk("c_busy_rst", bus.busy, 0);
      chk("c_we_rst", bus.mem_we, 0);
      chk("c_instr_rst", bus.fetch_instr, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dn = 0;
      repeat (8) begin @(negedge clk); if (bus.fetch_done) dn++; end
      chk("c_no_done", dn, 0);

      // Random traffic, checked by the reference model
      rn = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         fh = bus.fetch_valid && bus.fetch_ready;
         lh = bus.load_valid && bus.load_ready;
         if (fh || lh) rn++;
         @(posedge clk); #1;
         if (fh || (bus.fetch_valid && $urandom_range(7) == 0)) bus.fetch_valid = 1'b0;
         else if (!bus.fetch_valid && $urandom_range(2) == 0) begin
            bus.fetch_valid = 1'b1; bus.fetch_addr = $urandom;
         end
         if (lh || (bus.load_valid && $urandom_range(7) == 0)) bus.load_valid = 1'b0;
         else if (!bus.load_valid && $urandom_range(2) == 0) begin
            bus.load_valid = 1'b1; bus.load_addr = 8'($urandom); bus.load_data = 8'($urandom);
         end
      end
      bus.fetch_valid = 1'b0; bus.load_valid = 1'b0;
      hs = rn > 20;
      chk("rand_activity", hs, 1);
      repeat (10) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
